// File: rtl/cmd_rx_auth.sv
// Rider-command receiver: 8N1 UART receive path feeding a small authorization
// FSM that turns 'G'/'S' command bytes into the pwr_up enable for the balancer.
module cmd_rx_auth #(
  parameter int          BAUD_DIV = 2604,
  parameter logic [7:0]  GO_CMD   = 8'h47,
  parameter logic [7:0]  STOP_CMD = 8'h53
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam int CW = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
  // Counting down to zero inclusive, so reload one less to keep a full bit period.
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

  logic rx_meta, rx_sync, rx_prev;
  logic start_edge;

  rx_state_t   rx_st, rx_nxt;
  auth_state_t auth_st, auth_nxt;

  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    data_nxt;
  logic          rdy_nxt, err_nxt;
  logic          baud_zero;
  logic          got_go, got_stop;

  // Synchronizer flops preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;
  assign baud_zero  = (baud_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_st    <= rx_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      rx_data  <= data_nxt;
      rx_rdy   <= rdy_nxt;
      frm_err  <= err_nxt;
    end
  end

  always_comb begin
    rx_nxt    = rx_st;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = rx_data;
    rdy_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (rx_st)
      IDLE: begin
        if (start_edge) begin
          rx_nxt   = START;
          baud_nxt = HALF_BIT;
        end
      end
      START: begin
        if (!baud_zero) begin
          baud_nxt = baud_cnt - CW'(1);
        end else if (rx_sync) begin
          rx_nxt = IDLE;
        end else begin
          rx_nxt   = DATA;
          baud_nxt = FULL_BIT;
          bit_nxt  = '0;
        end
      end
      DATA: begin
        if (!baud_zero) begin
          baud_nxt = baud_cnt - CW'(1);
        end else begin
          shift_nxt = {rx_sync, shift[7:1]};
          baud_nxt  = FULL_BIT;
          bit_nxt   = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) rx_nxt = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE mid stop bit leaves room for a back-to-back start edge.
        if (!baud_zero) begin
          baud_nxt = baud_cnt - CW'(1);
        end else begin
          rx_nxt = IDLE;
          if (rx_sync) begin
            data_nxt = shift;
            rdy_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: rx_nxt = IDLE;
    endcase
  end

  assign got_go   = rx_rdy && (rx_data == GO_CMD);
  assign got_stop = rx_rdy && (rx_data == STOP_CMD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth_st <= OFF;
      pwr_up  <= 1'b0;
    end else begin
      auth_st <= auth_nxt;
      pwr_up  <= (auth_nxt != OFF);
    end
  end

  // PWR2 keeps power up after a stop request until the rider actually leaves.
  always_comb begin
    auth_nxt = auth_st;
    case (auth_st)
      OFF:  if (got_go) auth_nxt = PWR1;
      PWR1: if (got_stop) auth_nxt = rider_off ? OFF : PWR2;
      PWR2: begin
        if (got_go)         auth_nxt = PWR1;
        else if (rider_off) auth_nxt = OFF;
      end
      default: auth_nxt = OFF;
    endcase
  end

endmodule
